data_memory_unit: RTL
=====================

Name: data_memory_unit

Overview:
Parametrised, byte-addressable data memory for the MEM stage of the pipelined core. It is the next-generation replacement for the fixed 32-word, word-only data memory. Adds byte/half/word loads and stores, sign/zero extension, misalignment and range checking, and a valid/ready request with a configurable wait-state count. The MEM stage stalls on req_ready low.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; power of two, 4..65536
ADDR_W, 32, byte-address width of req_addr
WAIT_STATES, 0, extra cycles before the response; 0..7

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_write  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
req_unsigned  input  1  load zero-extends when 1, sign-extends when 0
req_addr  input  ADDR_W  byte address
req_wdata  input  32  store data, right-justified
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, out of range, or reserved size

Behaviour:
- Reset (rst low, asynchronous):
  - State goes to IDLE; wait counter = 0.
  - req_ready = 1 after reset deassertion; resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Any in-flight request is dropped and its write is never committed.
  - Array contents are not reset and are retained.
- States: IDLE, WAIT, RESP.
  - req_ready = 1 in IDLE and RESP, 0 in WAIT.
  - A request is accepted on a clock edge where req_valid && req_ready. Request fields are captured in registers at acceptance.
  - On acceptance: go to WAIT with counter = WAIT_STATES-1 if WAIT_STATES > 0, else go to RESP.
  - WAIT: decrement the counter; at 0, go to RESP.
  - RESP: resp_valid = 1 for exactly that cycle. Next state is WAIT/RESP if a new request is accepted in the same cycle, else IDLE.
- Latency: acceptance edge to resp_valid = WAIT_STATES+1 cycles.
  - Throughput with WAIT_STATES = 0 is one request per cycle.
- Commit point: the array write and the read sampling both occur on the edge that enters RESP.
  - A load issued after a store to the same address returns the stored data.
  - Loads never return stale data.
- Alignment and extract:
  - Byte: lane = addr[1:0]; load extends bit 7.
  - Half: lane = addr[1]; load extends bit 15.
  - Word: all four lanes.
  - Store writes only the selected lanes; all other bytes in the word are unchanged.
- Errors (checked at acceptance):
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - req_size = 11
  - word index addr[ADDR_W-1:2] >= DEPTH_WORDS
- Error response: resp_err = 1, resp_rdata = 0, no array write, same latency as a normal access.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper bits are used only for the range check; there is no wrap-around aliasing.
- resp_rdata and resp_err hold their last values between responses. They are valid only while resp_valid is high.
- req_valid dropped while req_ready = 0 has no effect, because fields are captured at acceptance.

Decomposition:
- Shared package dmem_pkg:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD
  - state enum for IDLE, WAIT, RESP
  - function for log2 of DEPTH_WORDS
- One sub-module, dmem_lane_align (combinational):
  - store: produces the 4-bit byte enable and the lane-shifted write data from size and addr[1:0]
  - load: extracts and extends read data, and flags misalignment
- The top level holds the FSM, the wait counter, the captured request and the array.

Test Plan:
1. WAIT_STATES=0: store word 0xDEADBEEF @0x10, then load word @0x10 back-to-back -> resp_valid on consecutive cycles; load returns 0xDEADBEEF, resp_err = 0.
2. Store byte 0x80 @0x13 over 0x11223344; load byte signed @0x13 -> 0xFFFFFF80; load unsigned -> 0x00000080; load word -> 0x80223344.
3. Load half @0x12 signed from 0x80223344 -> 0xFFFF8022. Load half @0x11 -> resp_err = 1, rdata = 0. Store word @0x12 -> resp_err = 1 and memory unchanged.
4. WAIT_STATES=3: request accepted at cycle t -> req_ready low t+1..t+3, resp_valid at t+4; a second req_valid held during WAIT is accepted at t+4.
5. DEPTH_WORDS=256: load @0x400 -> resp_err = 1; req_size = 11 @0x0 -> resp_err = 1, no write.
6. WAIT_STATES=3: store word 0x12345678 @0x20, rst pulsed low during WAIT -> outputs 0 immediately and req_ready = 1 after release; load @0x20 returns prior contents, not 0x12345678.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and helpers for the byte-addressable data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Request fields held from acceptance until the commit edge.
    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        unsigned_ld;
        logic [1:0]  offset;
        logic        oor;
        logic [31:0] wdata;
    } req_t;

    function automatic int unsigned log2_words(input int unsigned depth);
        int unsigned n = 0;
        int unsigned v = 1;
        while (v < depth) begin
            v = v << 1;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated write data, load
// extraction with sign/zero extension, and alignment checking.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  byte_en_c_o,
    output logic [31:0] wdata_c_o,
    output logic [31:0] rdata_c_o,
    output logic        misalign_c_o
);

    logic [31:0] byte_shift;
    logic [15:0] half_sel;
    logic        ext;

    always_comb begin
        byte_en_c_o  = 4'b0000;
        wdata_c_o    = wdata_i;
        rdata_c_o    = 32'h0000_0000;
        misalign_c_o = 1'b0;
        ext          = 1'b0;
        byte_shift   = rword_i >> {offset_i, 3'b000};
        half_sel     = offset_i[1] ? rword_i[31:16] : rword_i[15:0];
        case (size_i)
            SZ_BYTE: begin
                // Replicating the byte lets the enable alone pick the lane.
                byte_en_c_o = 4'b0001 << offset_i;
                wdata_c_o   = {4{wdata_i[7:0]}};
                ext         = ~unsigned_i & byte_shift[7];
                rdata_c_o   = {{24{ext}}, byte_shift[7:0]};
            end
            SZ_HALF: begin
                misalign_c_o = offset_i[0];
                byte_en_c_o  = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_c_o    = {2{wdata_i[15:0]}};
                ext          = ~unsigned_i & half_sel[15];
                rdata_c_o    = {{16{ext}}, half_sel};
            end
            SZ_WORD: begin
                misalign_c_o = (offset_i != 2'b00);
                byte_en_c_o  = 4'b1111;
                rdata_c_o    = rword_i;
            end
            default: begin
                byte_en_c_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/data_memory_unit.sv
// MEM-stage data memory: valid/ready request, configurable wait states,
// byte/half/word access with extension and error checking.
module data_memory_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);

    localparam int unsigned IDX_W     = log2_words(DEPTH_WORDS);
    localparam int unsigned CNT_W     = 3;
    localparam bit          ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [CNT_W-1:0] CNT_INIT =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ready_q, ready_d;
    req_t              req_q, req_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              valid_q, valid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    req_t              live_req;
    logic [IDX_W-1:0]  live_idx;
    logic              live_oor;
    req_t              cur_req;
    logic [IDX_W-1:0]  cur_idx;
    logic [31:0]       rword;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_al;
    logic [31:0]       ld_data;
    logic              misalign;
    logic              cur_err;
    logic              accept_c;
    logic              commit_c;

    // Upper address bits only feed the range check; the index never wraps.
    assign live_idx = req_addr[IDX_W+1:2];
    assign live_oor = ((req_addr >> (IDX_W + 2)) != '0);
    assign live_req = '{
        write:       req_write,
        size:        req_size,
        unsigned_ld: req_unsigned,
        offset:      req_addr[1:0],
        oor:         live_oor,
        wdata:       req_wdata
    };

    // With no wait states the commit edge is the acceptance edge itself.
    assign cur_req  = ZERO_WAIT ? live_req : req_q;
    assign cur_idx  = ZERO_WAIT ? live_idx : idx_q;
    assign accept_c = req_valid && ready_q;
    assign commit_c = ZERO_WAIT ? accept_c
                                : ((state_q == ST_WAIT) && (cnt_q == '0));
    assign rword    = mem_q[cur_idx];
    assign cur_err  = misalign || (cur_req.size == SZ_RSVD) || cur_req.oor;

    dmem_lane_align u_lane_align (
        .size_i       (cur_req.size),
        .offset_i     (cur_req.offset),
        .unsigned_i   (cur_req.unsigned_ld),
        .wdata_i      (cur_req.wdata),
        .rword_i      (rword),
        .byte_en_c_o  (byte_en),
        .wdata_c_o    (wdata_al),
        .rdata_c_o    (ld_data),
        .misalign_c_o (misalign)
    );

    // Next-state, counter, request capture and response registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        idx_d   = idx_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (accept_c) begin
            req_d = live_req;
            idx_d = live_idx;
        end

        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    if (ZERO_WAIT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = CNT_W'(cnt_q - 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (commit_c) begin
            valid_d = 1'b1;
            err_d   = cur_err;
            rdata_d = (cur_err || cur_req.write) ? 32'h0000_0000 : ld_data;
        end

        ready_d = (state_d != ST_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            req_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            req_q   <= req_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset before the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (commit_c && cur_req.write && !cur_err) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem_q[cur_idx][8*b +: 8] <= wdata_al[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
